imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 19 +
 rtl/imem_grant_logic.sv | 54 +++++
 rtl/imem_arbiter.sv | 85 ++++++++
 tb/tb_imem_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM encodings,
// default sizing and the address legality check used by both request ports.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_LAST_FETCH = 2'b01,
    ST_LAST_LOAD  = 2'b10
  } arb_state_t;

  localparam int unsigned DEF_MEM_WORDS    = 256;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // A request is illegal if it is not word aligned or falls past the last word.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned mem_words);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= (33'(mem_words) << 2));
  endfunction

endpackage

// File: rtl/imem_grant_logic.sv
// Loader-over-fetch priority with a starvation counter that forces a fetch
// grant after STARVE_LIMIT consecutive loader wins.
module imem_grant_logic
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic load_req,
  output logic fetch_gnt,
  output logic load_gnt,
  output logic last_fetch
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t    state, state_next;
  logic [CW-1:0] starve_cnt;
  logic          starve_hit;

  assign starve_hit = fetch_req && (starve_cnt == CW'(STARVE_LIMIT));
  assign last_fetch = (state == ST_LAST_FETCH);

  // NOTE: every output gets a default before the decision tree so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    fetch_gnt  = 1'b0;
    load_gnt   = 1'b0;
    state_next = ST_IDLE;
    if (!reset) begin
      if (starve_hit)     fetch_gnt = 1'b1;
      else if (load_req)  load_gnt  = 1'b1;
      else if (fetch_req) fetch_gnt = 1'b1;
    end
    if (fetch_gnt)     state_next = ST_LAST_FETCH;
    else if (load_gnt) state_next = ST_LAST_LOAD;
  end

  // NOTE: reset is synchronous here, so it is tested inside the clocked
  // branch rather than appearing in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_next;
      if (fetch_gnt || !fetch_req) starve_cnt <= '0;
      else if (load_gnt)           starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one synchronous RAM port between CPU
// fetches and a program loader, returning fetch data one cycle after grant.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = DEF_MEM_WORDS,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_req,
  input  logic [31:0]                  fetch_addr,
  output logic                         fetch_gnt,
  output logic                         fetch_valid,
  output logic [31:0]                  fetch_data,
  output logic                         cpu_stall,
  input  logic                         load_req,
  input  logic [31:0]                  load_addr,
  input  logic [31:0]                  load_data,
  output logic                         load_gnt,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata,
  output logic                         addr_err
);

  localparam int AW = $clog2(MEM_WORDS);

  logic        last_fetch;
  logic        fetch_bad, load_bad;
  logic        fetch_err_q;
  logic [31:0] data_hold_q;

  imem_grant_logic #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .load_req   (load_req),
    .fetch_gnt  (fetch_gnt),
    .load_gnt   (load_gnt),
    .last_fetch (last_fetch)
  );

  assign fetch_bad = addr_bad(fetch_addr, MEM_WORDS);
  assign load_bad  = addr_bad(load_addr, MEM_WORDS);
  assign cpu_stall = fetch_req && !fetch_gnt;

  // Illegal requests are still granted but never reach the RAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt && !fetch_bad) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr[AW+1:2];
    end else if (load_gnt && !load_bad) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = load_addr[AW+1:2];
      mem_wdata = load_data;
    end
  end

  // Gating with reset drops the response of a fetch granted just before reset.
  assign fetch_valid = last_fetch && !reset;
  assign fetch_data  = fetch_valid ? (fetch_err_q ? 32'h0 : mem_rdata) : data_hold_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_err_q <= 1'b0;
      addr_err    <= 1'b0;
      data_hold_q <= '0;
    end else begin
      fetch_err_q <= fetch_gnt && fetch_bad;
      if ((fetch_gnt && fetch_bad) || (load_gnt && load_bad)) addr_err <= 1'b1;
      if (fetch_valid) data_hold_q <= fetch_data;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: table-driven cycles with a fetch-data
// scoreboard, a behavioural RAM, and a short randomised back-to-back burst.
module tb_imem_arbiter;

  localparam int MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, load_req;
  logic [31:0] fetch_addr, load_addr, load_data;
  logic        fetch_gnt, fetch_valid, cpu_stall, load_gnt;
  logic [31:0] fetch_data;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        addr_err;

  imem_arbiter #(.MEM_WORDS(MEM_WORDS), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .cpu_stall   (cpu_stall),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_gnt    (load_gnt),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM seen by the DUT.
  logic [31:0] ram [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic        rst;
    logic        freq;
    logic [31:0] faddr;
    logic        lreq;
    logic [31:0] laddr;
    logic [31:0] ldata;
    logic        exp_fgnt;
    logic        exp_lgnt;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] sb[$];
  logic [31:0] exp_hold;
  logic        exp_err;
  int          n_vec  = 0;
  int          n_miss = 0;

  function automatic vec_t mk(input logic rst, input logic freq, input logic [31:0] fa,
                              input logic lreq, input logic [31:0] la, input logic [31:0] ld,
                              input logic ef, input logic el);
    vec_t v;
    v.rst = rst; v.freq = freq; v.faddr = fa; v.lreq = lreq;
    v.laddr = la; v.ldata = ld; v.exp_fgnt = ef; v.exp_lgnt = el;
    return v;
  endfunction

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd1024);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    logic        fb, lb, pend, exp_en, exp_we;
    logic [31:0] exp_d;
    @(posedge clk);
    #1;
    reset      = v.rst;
    fetch_req  = v.freq;
    fetch_addr = v.faddr;
    load_req   = v.lreq;
    load_addr  = v.laddr;
    load_data  = v.ldata;
    @(negedge clk);
    pend = (sb.size() != 0);
    if (v.rst) begin
      check("rst_outputs", {fetch_gnt, load_gnt, mem_en, mem_we}, 4'b0000);
      check("rst_valid", fetch_valid, 1'b0);
      sb.delete();
      exp_err  = 1'b0;
      exp_hold = 32'h0;
    end else begin
      fb     = is_bad(v.faddr);
      lb     = is_bad(v.laddr);
      exp_en = (v.exp_fgnt && !fb) || (v.exp_lgnt && !lb);
      exp_we = v.exp_lgnt && !lb;
      check("grant", {fetch_gnt, load_gnt}, {v.exp_fgnt, v.exp_lgnt});
      check("cpu_stall", cpu_stall, v.freq && !v.exp_fgnt);
      check("mem_ctl", {mem_en, mem_we}, {exp_en, exp_we});
      if (exp_en) check("mem_addr", mem_addr, v.exp_fgnt ? v.faddr[9:2] : v.laddr[9:2]);
      if (exp_we) check("mem_wdata", mem_wdata, v.ldata);
      if (!v.freq && !v.lreq) check("idle_mem", {mem_addr, mem_wdata}, 40'h0);
      check("addr_err", addr_err, exp_err);
      check("fetch_valid", fetch_valid, pend);
      if (pend) begin
        exp_d = sb.pop_front();
        check("fetch_data", fetch_data, exp_d);
        exp_hold = exp_d;
      end else begin
        check("data_hold", fetch_data, exp_hold);
      end
      if (v.exp_fgnt) sb.push_back(fb ? 32'h0 : model_mem[v.faddr[9:2]]);
      if (v.exp_lgnt && !lb) model_mem[v.laddr[9:2]] = v.ldata;
      if ((v.exp_fgnt && fb) || (v.exp_lgnt && lb)) exp_err = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; fetch_req = 1'b0; load_req = 1'b0;
    fetch_addr = '0; load_addr = '0; load_data = '0;
    exp_hold = '0; exp_err = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      ram[i]       = 32'hC0DE_0000 | i;
      model_mem[i] = 32'hC0DE_0000 | i;
    end

    // rst freq faddr lreq laddr ldata exp_fgnt exp_lgnt
    vecs.push_back(mk(1, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 1, 0,  1, 0,  1, 0, 0));            // no grants under reset
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0,  0, 0,  0, 1, 0));            // fetch 0,4,8 back to back
    vecs.push_back(mk(0, 1, 4,  0, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1, 8,  0, 0,  0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0));            // fetch_data holds
    vecs.push_back(mk(0, 0, 0,  1, 12, 32'hDEAD_BEEF, 0, 1)); // load then same-word fetch
    vecs.push_back(mk(0, 1, 12, 0, 0,  0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 16, 0, 0,  0, 1, 0));            // load coincides with fetch_valid
    vecs.push_back(mk(0, 0, 0,  1, 20, 32'h1234_5678, 0, 1));
    for (int i = 0; i < 10; i++)                               // contention L,L,L,L,F x2
      vecs.push_back(mk(0, 1, 20, 1, 24, 32'hA500_0000 + i, (i % 5) == 4, (i % 5) != 4));
    vecs.push_back(mk(0, 1, 24, 0, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1, 6,  0, 0,  0, 1, 0));            // misaligned fetch
    vecs.push_back(mk(0, 0, 0,  1, 1024, 32'hBAD0_0000, 0, 1)); // out-of-range load
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 1020, 0, 0, 0, 1, 0));           // last legal word
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 1023, 0, 0, 0, 1, 0));           // in range but misaligned
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0));
    for (int i = 0; i < 3; i++)                                // build starve count to 3
      vecs.push_back(mk(0, 1, 0, 1, 28, 32'h5500_0000 + i, 0, 1));
    vecs.push_back(mk(1, 1, 0,  1, 28, 0, 0, 0));
    for (int i = 0; i < 5; i++)                                // count restarts from 0
      vecs.push_back(mk(0, 1, 0, 1, 32, 32'h6600_0000 + i, i == 4, i != 4));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 8,  0, 0,  0, 1, 0));            // fetch, then reset next cycle
    vecs.push_back(mk(1, 1, 8,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Randomised full-throughput fetch burst.
    for (int i = 0; i < 8; i++)
      apply(mk(0, 1, 32'($urandom_range(0, MEM_WORDS - 1)) << 2, 0, 0, 0, 1, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
